// File: rtl/bitcell_array_ctrl.sv
// Access controller for a ROWS x WIDTH SR-latch bitcell array.
// Optional write-verify readback: define BITCELL_ARRAY_CTRL_VERIFY_EN.
module bitcell_array_ctrl #(
  parameter int ROWS         = 4,
  parameter int WIDTH        = 4,
  parameter int ADDR_W       = $clog2(ROWS),
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
  output logic              wr_err,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic [ROWS-1:0]   arr_sel,
  output logic              arr_read,
  output logic [WIDTH-1:0]  arr_in,
  input  logic [WIDTH-1:0]  arr_out
);

  localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WRITE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ACCESS,
    R_SAMPLE,
    V_ACCESS,
    V_SAMPLE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [ROWS-1:0]  sel_nxt;
  logic [WIDTH-1:0] in_nxt;
  logic [WIDTH-1:0] rdata_nxt;
  logic             read_nxt;
  logic             rsp_nxt;
  logic             accept;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
  logic             err_nxt;
`endif

  // Out-of-range addresses decode to no row at all.
  function automatic logic [ROWS-1:0] dec(input logic [ADDR_W-1:0] a);
    dec = '0;
    for (int i = 0; i < ROWS; i++)
      if (a == ADDR_W'(i)) dec[i] = 1'b1;
  endfunction

  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = arr_sel;
    in_nxt    = arr_in;
    rdata_nxt = rsp_rdata;
    read_nxt  = 1'b1;
    rsp_nxt   = 1'b0;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
    err_nxt   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        sel_nxt = '0;
        if (accept) begin
          sel_nxt = dec(req_addr);
          if (req_write) begin
            state_nxt = W_SETUP;
            in_nxt    = req_wdata;
          end else begin
            state_nxt = R_ACCESS;
          end
        end
      end
      W_SETUP: begin
        state_nxt = W_PULSE;
        read_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
      W_PULSE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = W_HOLD;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          read_nxt = 1'b0;
        end
      end
      W_HOLD: begin
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
        state_nxt = V_ACCESS;
`else
        state_nxt = IDLE;
        sel_nxt   = '0;
`endif
      end
      R_ACCESS: state_nxt = R_SAMPLE;
      R_SAMPLE: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
        rsp_nxt   = 1'b1;
        rdata_nxt = (arr_sel == '0) ? '0 : arr_out;
      end
      V_ACCESS: state_nxt = V_SAMPLE;
      V_SAMPLE: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
        // arr_in still carries the data just written.
        err_nxt   = (arr_sel != '0) && (arr_out != arr_in);
`endif
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      arr_sel   <= '0;
      arr_read  <= 1'b1;
      arr_in    <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= rsp_nxt;
      rsp_rdata <= rdata_nxt;
      arr_sel   <= sel_nxt;
      arr_read  <= read_nxt;
      arr_in    <= in_nxt;
    end
  end

`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= err_nxt;
  end
`endif

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Randomized bench for bitcell_array_ctrl with a bitcell array model
// and a word-level reference memory.
module tb_bitcell_array_ctrl;

  localparam int ROWS  = 6;
  localparam int WIDTH = 4;
  localparam int AW    = 3;
  localparam int WC    = 3;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
  localparam int VX = 2;
`else
  localparam int VX = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic [ROWS-1:0]  arr_sel;
  logic             arr_read;
  logic [WIDTH-1:0] arr_in;
  logic [WIDTH-1:0] arr_out;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
  logic             wr_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  bitcell_array_ctrl #(
    .ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(AW), .WRITE_CYCLES(WC)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
    .wr_err(wr_err),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .arr_sel(arr_sel),
    .arr_read(arr_read),
    .arr_in(arr_in),
    .arr_out(arr_out)
  );

  always #5 clk = ~clk;

  // Bitcell array: a row latches arr_in while selected with read low.
  logic [WIDTH-1:0] cells [ROWS];
  logic [WIDTH-1:0] stuck_mask = '1;

  always @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      if (arr_sel[r] && !arr_read) cells[r] <= arr_in;

  always_comb begin
    arr_out = '0;
    for (int r = 0; r < ROWS; r++)
      if (arr_sel[r] && arr_read) arr_out = arr_out | cells[r];
    arr_out = arr_out & stuck_mask;
  end

  int ref_mem [ROWS];
  bit known   [ROWS];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Protocol monitor
  bit               mon_en = 1'b0;
  logic [ROWS-1:0]  p_sel  = '0;
  logic [WIDTH-1:0] p_in   = '0;
  logic             p_read = 1'b1;

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      check("onehot0", 32'($onehot0(arr_sel)), 1);
      if (!arr_read || !p_read) begin
        check("sel_stable", 32'(arr_sel), 32'(p_sel));
        check("in_stable", 32'(arr_in), 32'(p_in));
      end
    end
    p_sel  = arr_sel;
    p_in   = arr_in;
    p_read = arr_read;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic do_write(input int a, input int d, input bit noisy);
    int n = 0;
    int low = 0;
    int errs = 0;
    int exp_err;
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = AW'(a);
    req_wdata = WIDTH'(d);
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (!arr_read) low++;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
      if (wr_err) errs++;
`endif
      if (req_ready) break;
      if (noisy) begin
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = WIDTH'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("wr_latency", n, WC + 3 + VX);
    check("wr_pulse_len", low, WC);
    exp_err = 0;
`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
    exp_err = (a < ROWS && ((d & int'(stuck_mask)) != d)) ? 1 : 0;
`endif
    check("wr_err_count", errs, exp_err);
    if (a < ROWS) begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
    end
  endtask

  task automatic do_read(input int a);
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = AW'(a);
    req_wdata = WIDTH'($urandom);
    @(posedge clk);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      check("rsp_valid_timing", 32'(rsp_valid), (i == 3) ? 1 : 0);
    end
    check("rd_ready_back", 32'(req_ready), 1);
    if (a >= ROWS) check("rd_oob", 32'(rsp_rdata), 0);
    else if (known[a]) check("rd_data", 32'(rsp_rdata), ref_mem[a]);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int r = 0; r < ROWS; r++) known[r] = 1'b0;
    #12;
    check("rst_ready", 32'(req_ready), 1);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    check("rst_sel", 32'(arr_sel), 0);
    check("rst_read", 32'(arr_read), 1);
    check("rst_in", 32'(arr_in), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    do_write(2, 4'b1010, 0);
    do_read(2);

    for (int r = 0; r < ROWS; r++) do_write(r, 4'hF, 0);
    do_write(1, 4'h0, 0);
    for (int r = 0; r < ROWS; r++) do_read(r);

    do_write(4, 4'h6, 1);
    for (int r = 0; r < ROWS; r++) do_read(r);

    do_write(7, 4'h9, 0);
    do_read(7);
    do_read(6);

    // Reset in the middle of a write pulse
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd3;
    req_wdata = 4'h5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("in_pulse", 32'(arr_read), 0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_read", 32'(arr_read), 1);
    check("mid_rst_sel", 32'(arr_sel), 0);
    check("mid_rst_ready", 32'(req_ready), 1);
    check("mid_rst_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    known[3] = 1'b0;
    do_write(3, 4'hC, 0);
    do_read(3);

    for (int k = 0; k < 80; k++) begin
      int a = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom_range(0, 15), 0);
      else do_read(a);
    end

`ifdef BITCELL_ARRAY_CTRL_VERIFY_EN
    stuck_mask = 4'b1110;
    do_write(0, 4'b0001, 0);
    stuck_mask = '1;
    do_write(0, 4'b0001, 0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
